// File: rtl/vga_sync_if.sv
// VGA timing link as seen by a receive-side monitor: sync/blank inputs plus recovered position and status.
// Latency: none, this is a plain bundle of wires.
// Backpressure: none, the link is free-running and the monitor only observes it.
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       blank_b;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [7:0] err_count;

    // timing source side: drives the syncs, may read back the monitor status
    modport master (
        output hsync, vsync, blank_b,
        input  x, y, active, locked, frame_start, sync_err, err_count
    );

    // monitor side
    modport slave (
        input  hsync, vsync, blank_b,
        output x, y, active, locked, frame_start, sync_err, err_count
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers x/y from hsync/vsync, locks to the frame, flags timing violations.
// Latency: x/y describe the sample currently on the inputs (zero latency); status outputs are registered, 1 cycle.
// Backpressure: none; the link is free-running, every sample is consumed on every vgaclk edge.
module vga_sync_monitor #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 11,
    parameter int VSYN    = 2,
    parameter int VBP     = 32,
    parameter int TIMEOUT = 2 * (HACTIVE + HFP + HSYN + HBP)
) (
    input  logic      vgaclk,
    input  logic      reset,
    vga_sync_if.slave vga
);
    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

    localparam logic [9:0]  H_ACT      = 10'(HACTIVE);
    localparam logic [9:0]  H_SYNC_AT  = 10'(HACTIVE + HFP);
    localparam logic [9:0]  H_AFTER    = 10'(HACTIVE + HFP + 1);
    localparam logic [9:0]  H_LAST     = 10'(HMAX - 1);
    localparam logic [9:0]  V_ACT      = 10'(VACTIVE);
    localparam logic [9:0]  V_SYNC_AT  = 10'(VACTIVE + VFP);
    localparam logic [9:0]  V_LAST     = 10'(VMAX - 1);
    localparam logic [11:0] TO_LIMIT   = 12'(TIMEOUT);
    localparam logic [11:0] TO_TRIGGER = 12'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        prev_hsync, prev_vsync;
    logic [9:0]  x_q, y_q, x_nxt, y_nxt;
    logic [11:0] tcnt;
    logic        active_q, frame_start_q, sync_err_q;
    logic [7:0]  err_count_q;
    logic        hfall, vfall, hok, vok, bok, timeout;
    logic        err_nxt;

    // Sync edges are judged on the current sample against the previous one.
    assign hfall = prev_hsync & ~vga.hsync;
    assign vfall = prev_vsync & ~vga.vsync;

    // Checks use the predicted position of the current sample (x/y before update).
    assign hok     = ~hfall | (x_q == H_SYNC_AT);
    assign vok     = ~vfall | ((x_q == 10'd0) & (y_q == V_SYNC_AT));
    assign bok     = vga.blank_b == ((x_q < H_ACT) & (y_q < V_ACT));
    assign timeout = ~hfall & (tcnt == TO_TRIGGER);

    // Position tracking: hsync/vsync falls snap the counters, otherwise free-run with wrap.
    always_comb begin
        x_nxt = (x_q == H_LAST) ? 10'd0 : x_q + 10'd1;
        y_nxt = y_q;
        if (hfall) begin
            x_nxt = H_AFTER;
        end else if (x_q == H_LAST) begin
            y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        if (vfall) begin
            y_nxt = V_SYNC_AT;
        end
    end

    // Lock FSM: next state and the error strobe (only a lost lock counts as an error).
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            SEARCH: begin
                if (vfall) state_nxt = ALIGN;
            end
            ALIGN: begin
                if (~hok)             state_nxt = SEARCH;
                else if (vfall & vok) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (~hok | ~vok | ~bok | timeout) begin
                    state_nxt = SEARCH;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
        if (timeout) state_nxt = SEARCH;
    end

    // FSM state register.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) state <= SEARCH;
        else       state <= state_nxt;
    end

    // Edge history, position counters and the hsync watchdog.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            prev_hsync <= 1'b0;
            prev_vsync <= 1'b0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            tcnt       <= 12'd0;
        end else begin
            prev_hsync <= vga.hsync;
            prev_vsync <= vga.vsync;
            x_q        <= x_nxt;
            y_q        <= y_nxt;
            if (hfall)                tcnt <= 12'd0;
            else if (tcnt != TO_LIMIT) tcnt <= tcnt + 12'd1;
        end
    end

    // Registered status, aligned with the post-update position and lock.
    always_ff @(posedge vgaclk or posedge reset) begin
        if (reset) begin
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            err_count_q   <= 8'd0;
        end else begin
            active_q      <= (state_nxt == LOCKED) & (x_nxt < H_ACT) & (y_nxt < V_ACT);
            frame_start_q <= (state_nxt == LOCKED) & (x_nxt == 10'd0) & (y_nxt == 10'd0);
            sync_err_q    <= err_nxt;
            if (err_nxt && err_count_q != 8'hff) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.locked      = (state == LOCKED);
    assign vga.active      = active_q;
    assign vga.frame_start = frame_start_q;
    assign vga.sync_err    = sync_err_q;
    assign vga.err_count   = err_count_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a reduced 10x5 geometry driven by an in-bench VGA timing source.
// Latency: expected positions are queued when a sample is driven and compared after the next edge.
// Backpressure: none; faults are injected by overriding the source syncs/blank for chosen samples.
module tb_vga_sync_monitor;
    localparam int HA = 4, HF = 1, HY = 4, HB = 1;
    localparam int VA = 2, VF = 1, VY = 1, VB = 1;
    localparam int HMAX  = HA + HF + HY + HB;
    localparam int VMAX  = VA + VF + VY + VB;
    localparam int FRAME = HMAX * VMAX;
    localparam int HS    = HA + HF;
    localparam int VSA   = VA + VF;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       fs;
    } exp_t;

    logic vgaclk = 1'b0;
    logic reset;
    vga_sync_if vif();

    vga_sync_monitor #(
        .HACTIVE(HA), .HFP(HF), .HSYN(HY), .HBP(HB),
        .VACTIVE(VA), .VFP(VF), .VSYN(VY), .VBP(VB),
        .TIMEOUT(2 * HMAX)
    ) dut (
        .vgaclk (vgaclk),
        .reset  (reset),
        .vga    (vif)
    );

    always #5 vgaclk = ~vgaclk;

    exp_t       sb[$];
    int         gx, gy;
    bit         track, flip, delay_pending;
    int         hold_h;
    int         total, bad, fs_seen;
    logic [7:0] exp_cnt;

    function automatic logic [31:0] status();
        return {vif.x, vif.y, vif.locked, vif.active, vif.frame_start, vif.sync_err, vif.err_count};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Drive the source outputs for position (gx, gy), applying any armed fault.
    task automatic drive();
        logic hs, vs, bl;
        hs = !(gx >= HS && gx < HS + HY);
        if (delay_pending && gx >= HS && gx < HS + 3) hs = 1'b1;
        if (delay_pending && gx == HS + 3) delay_pending = 1'b0;
        if (hold_h > 0) begin
            hs = 1'b1;
            hold_h--;
        end
        vs = !(gy >= VSA && gy < VSA + VY);
        bl = (gx < HA) && (gy < VA);
        if (flip) begin
            bl   = !bl;
            flip = 1'b0;
        end
        vif.hsync   = hs;
        vif.vsync   = vs;
        vif.blank_b = bl;
    endtask

    task automatic tick();
        exp_t e;
        int   nx, ny;
        @(posedge vgaclk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("track", status(), {e.x, e.y, 1'b1, e.act, e.fs, 1'b0, exp_cnt});
        end
        if (track && vif.frame_start) fs_seen++;
        if (gx == HMAX - 1) begin
            gx = 0;
            gy = (gy == VMAX - 1) ? 0 : gy + 1;
        end else begin
            gx = gx + 1;
        end
        drive();
        if (track) begin
            nx = (gx == HMAX - 1) ? 0 : gx + 1;
            ny = (gx == HMAX - 1) ? ((gy == VMAX - 1) ? 0 : gy + 1) : gy;
            e.x   = 10'(nx);
            e.y   = 10'(ny);
            e.act = (nx < HA) && (ny < VA);
            e.fs  = (nx == 0) && (ny == 0);
            sb.push_back(e);
        end
    endtask

    // Advance until the source is driving (px, py).
    task automatic wait_gen(input int px, input int py);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(gx == px && gy == py) && n < 2 * FRAME);
    endtask

    task automatic wait_lock(input string tag, input int bound);
        int n;
        n = 0;
        while (!vif.locked && n < bound) begin
            tick();
            n++;
        end
        check(tag, 32'(vif.locked), 32'd1);
    endtask

    task automatic track_frames(input int n);
        track = 1'b1;
        repeat (n * FRAME) tick();
        track = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; fs_seen = 0;
        track = 1'b0; flip = 1'b0; delay_pending = 1'b0; hold_h = 0;
        exp_cnt = 8'd0;
        gx = 0; gy = 0;
        reset = 1'b1;
        drive();

        // reset state
        repeat (3) @(posedge vgaclk);
        #1;
        check("rst_all", status(), 32'd0);
        check("rst_locked", 32'(vif.locked), 32'd0);
        check("rst_err_count", 32'(vif.err_count), 32'd0);
        reset = 1'b0;

        // initial lock: vfall samples are index 30 and 80, lock visible after edge 81
        for (int n = 1; n <= 81; n++) begin
            tick();
            if (n == 80) check("lock_before_2nd_vfall", 32'(vif.locked), 32'd0);
            if (n == 81) check("lock_after_2nd_vfall", 32'(vif.locked), 32'd1);
        end
        track_frames(2);

        // hfall delayed by 3 clocks on line 1
        wait_gen(0, 1);
        delay_pending = 1'b1;
        wait_gen(HS + 2, 1);
        check("pre_delay_locked", 32'(vif.locked), 32'd1);
        tick();
        check("pre_delay_no_err", 32'(vif.sync_err), 32'd0);
        tick();
        exp_cnt = 8'd1;
        check("delay_err", {vif.sync_err, vif.locked, vif.err_count}, {1'b1, 1'b0, 8'd1});
        tick();
        check("delay_err_one_pulse", 32'(vif.sync_err), 32'd0);
        wait_gen(0, VSA);
        tick();
        check("delay_align_not_locked", 32'(vif.locked), 32'd0);
        wait_gen(0, VSA);
        check("delay_pre_relock", 32'(vif.locked), 32'd0);
        tick();
        check("delay_relock", 32'(vif.locked), 32'd1);
        track_frames(1);

        // blank_b forced low at visible pixel (1,1)
        wait_gen(0, 1);
        flip = 1'b1;
        tick();
        check("pre_blank_active", {vif.active, vif.locked}, 2'b11);
        tick();
        exp_cnt = 8'd2;
        check("blank_err", {vif.sync_err, vif.locked, vif.active, vif.err_count}, {3'b100, 8'd2});
        tick();
        check("blank_err_one_pulse", 32'(vif.sync_err), 32'd0);
        wait_lock("blank_relock", 3 * FRAME);
        track_frames(1);

        // hsync held high for 2*HMAX+1 clocks from its fall point on line 1
        wait_gen(HS - 1, 1);
        hold_h = 2 * HMAX + 1;
        repeat (11) tick();
        check("pre_timeout", {vif.sync_err, vif.locked}, 2'b01);
        tick();
        exp_cnt = 8'd3;
        check("timeout_err", {vif.sync_err, vif.locked, vif.err_count}, {2'b10, 8'd3});
        tick();
        check("timeout_err_one_pulse", 32'(vif.sync_err), 32'd0);
        wait_lock("timeout_relock", 4 * FRAME);
        track_frames(1);

        // error count saturation
        for (int i = 0; i < 300; i++) begin
            wait_lock("sat_relock", 3 * FRAME);
            flip = 1'b1;
            tick();
            tick();
            if (exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
            check("sat_err", {vif.sync_err, vif.err_count}, {1'b1, exp_cnt});
        end
        check("sat_final", 32'(vif.err_count), 32'd255);

        // reset in the middle of the visible area
        wait_lock("pre_rst_lock", 3 * FRAME);
        wait_gen(2, 1);
        check("pre_rst_pos", {vif.x, vif.y, vif.active}, {10'd2, 10'd1, 1'b1});
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 8'd0;
        check("rst_mid_immediate", status(), 32'd0);
        tick();
        check("rst_mid_held_1", status(), 32'd0);
        tick();
        check("rst_mid_held_2", status(), 32'd0);
        reset = 1'b0;
        wait_lock("rst_relock", 3 * FRAME);
        track_frames(1);

        // frame_start: exactly one per frame, at (0,0)
        fs_seen = 0;
        track_frames(3);
        tick();
        check("frame_start_count", 32'(fs_seen), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
